wishbone_manager: RTL and testbench



---
 rtl/wb_pkg.sv | 23 ++
 rtl/wb_timeout_counter.sv | 31 +++
 rtl/wishbone_manager.sv | 101 ++++++++++
 tb/tb_wishbone_manager.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone manager types, address map and defaults.
// Optional timeout abort is enabled by WB_MANAGER_TIMEOUT_EN.
package wb_pkg;

   typedef enum logic {
      WB_MGR_IDLE = 1'b0,
      WB_MGR_BUS  = 1'b1
   } wb_mgr_state_t;

   // Team windows are 32'h30X0_0000; the X nibble selects the project.
   localparam logic [31:0] WB_TEAM_BASE = 32'h3000_0000;
   localparam logic [31:0] WB_TEAM_MASK = 32'hFF0F_0000;
   localparam logic [31:0] WB_LA_BASE   = 32'h3100_0000;
   localparam logic [31:0] WB_GPIO_BASE = 32'h3200_0000;
   localparam logic [31:0] WB_SRAM_BASE = 32'h3300_0000;

   localparam int unsigned WB_TIMEOUT_DEFAULT = 255;

   function automatic logic wb_is_team(input logic [31:0] adr);
      return (adr & WB_TEAM_MASK) == WB_TEAM_BASE;
   endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Saturating BUS-cycle counter for the manager timeout.
// expired is high while the count sits at CYCLES-1.
module wb_timeout_counter #(
   parameter int unsigned CYCLES = 255
) (
   input  logic CLK,
   input  logic nRST,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned W = $clog2(CYCLES + 1);
   localparam logic [W-1:0] LAST = W'(CYCLES - 1);
   localparam logic [W-1:0] SAT  = W'(CYCLES);

   logic [W-1:0] count;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && count != SAT) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == LAST);

endmodule

// File: rtl/wishbone_manager.sv
// Single-outstanding Wishbone initiator: request pulse in, classic cycle out.
// Timeout abort path present only with WB_MANAGER_TIMEOUT_EN defined.
module wishbone_manager
   import wb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_DEFAULT
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        req_i,
   input  logic        we_req_i,
   input  logic [31:0] adr_req_i,
   input  logic [31:0] dat_req_i,
   input  logic [3:0]  sel_req_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [31:0] rdat_o,
   output logic        wbs_cyc_o,
   output logic        wbs_stb_o,
   output logic        wbs_we_o,
   output logic [31:0] wbs_adr_o,
   output logic [31:0] wbs_dat_o,
   output logic [3:0]  wbs_sel_o,
   input  logic        wbs_ack_i,
   input  logic [31:0] wbs_dat_i
);

   wb_mgr_state_t state;
   logic          expired;

`ifdef WB_MANAGER_TIMEOUT_EN
   wb_timeout_counter #(
      .CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .CLK     (CLK),
      .nRST    (nRST),
      .clear   (state == WB_MGR_IDLE),
      .enable  (state == WB_MGR_BUS && !wbs_ack_i),
      .expired (expired)
   );
`else
   logic unused_tmo;
   assign unused_tmo = (TIMEOUT_CYCLES > 1);
   assign expired    = 1'b0;
`endif

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= WB_MGR_IDLE;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         err_o     <= 1'b0;
         rdat_o    <= '0;
         wbs_cyc_o <= 1'b0;
         wbs_stb_o <= 1'b0;
         wbs_we_o  <= 1'b0;
         wbs_adr_o <= '0;
         wbs_dat_o <= '0;
         wbs_sel_o <= '0;
      end else begin
         done_o <= 1'b0;
         unique case (state)
            WB_MGR_IDLE: begin
               if (req_i) begin
                  wbs_cyc_o <= 1'b1;
                  wbs_stb_o <= 1'b1;
                  wbs_we_o  <= we_req_i;
                  wbs_adr_o <= adr_req_i;
                  wbs_dat_o <= dat_req_i;
                  wbs_sel_o <= sel_req_i;
                  busy_o    <= 1'b1;
                  state     <= WB_MGR_BUS;
               end
            end
            WB_MGR_BUS: begin
               // ACK takes priority over a coincident timeout
               if (wbs_ack_i || expired) begin
                  if (!wbs_ack_i) begin
                     rdat_o <= '0;
                  end else if (!wbs_we_o) begin
                     rdat_o <= wbs_dat_i;
                  end
                  err_o     <= !wbs_ack_i;
                  done_o    <= 1'b1;
                  busy_o    <= 1'b0;
                  wbs_cyc_o <= 1'b0;
                  wbs_stb_o <= 1'b0;
                  wbs_we_o  <= 1'b0;
                  wbs_adr_o <= '0;
                  wbs_dat_o <= '0;
                  wbs_sel_o <= '0;
                  state     <= WB_MGR_IDLE;
               end
            end
            default: state <= WB_MGR_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wishbone_manager.sv
// Self-checking bench for wishbone_manager: directed table,
// multi-cycle corner sequences and randomized transactions.
`timescale 1ns/1ps
module tb_wishbone_manager;

   localparam int T = 8;

`ifdef WB_MANAGER_TIMEOUT_EN
   localparam bit TMO = 1'b1;
`else
   localparam bit TMO = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        nRST;
   logic        req_i;
   logic        we_req_i;
   logic [31:0] adr_req_i;
   logic [31:0] dat_req_i;
   logic [3:0]  sel_req_i;
   logic        busy_o;
   logic        done_o;
   logic        err_o;
   logic [31:0] rdat_o;
   logic        wbs_cyc_o;
   logic        wbs_stb_o;
   logic        wbs_we_o;
   logic [31:0] wbs_adr_o;
   logic [31:0] wbs_dat_o;
   logic [3:0]  wbs_sel_o;
   logic        wbs_ack_i;
   logic [31:0] wbs_dat_i;

   wishbone_manager #(
      .TIMEOUT_CYCLES (T)
   ) dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .req_i     (req_i),
      .we_req_i  (we_req_i),
      .adr_req_i (adr_req_i),
      .dat_req_i (dat_req_i),
      .sel_req_i (sel_req_i),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .err_o     (err_o),
      .rdat_o    (rdat_o),
      .wbs_cyc_o (wbs_cyc_o),
      .wbs_stb_o (wbs_stb_o),
      .wbs_we_o  (wbs_we_o),
      .wbs_adr_o (wbs_adr_o),
      .wbs_dat_o (wbs_dat_o),
      .wbs_sel_o (wbs_sel_o),
      .wbs_ack_i (wbs_ack_i),
      .wbs_dat_i (wbs_dat_i)
   );

   always #5 CLK = ~CLK;

   // dly: BUS edge at which ACK is sampled (0 = never)
   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      int          dly;
      logic [31:0] rdata;
      logic        err;
      logic [31:0] rdat;
      int          lat;
   } vec_t;

   vec_t        vq[$];
   logic [31:0] m_rdat;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Outcome from the rules: ACK by edge T wins, otherwise abort at edge T.
   task automatic model(inout vec_t v);
      if (TMO && (v.dly == 0 || v.dly > T)) begin
         v.err  = 1'b1;
         v.lat  = T;
         m_rdat = '0;
      end else begin
         v.err = 1'b0;
         v.lat = v.dly;
         if (!v.we) m_rdat = v.rdata;
      end
      v.rdat = m_rdat;
   endtask

   task automatic run_txn(input vec_t v);
      int k;
      bit got;
      req_i     = 1'b1;
      we_req_i  = v.we;
      adr_req_i = v.adr;
      dat_req_i = v.dat;
      sel_req_i = v.sel;
      @(posedge CLK); #1;
      req_i     = 1'b0;
      adr_req_i = ~v.adr;
      dat_req_i = ~v.dat;
      chk("start_ctl", {busy_o, wbs_cyc_o, wbs_stb_o, wbs_we_o, done_o},
          {1'b1, 1'b1, 1'b1, v.we, 1'b0});
      chk("start_adr", wbs_adr_o, v.adr);
      k   = 0;
      got = 1'b0;
      while (!got && k < 300) begin
         k++;
         wbs_ack_i = (k == v.dly);
         wbs_dat_i = (k == v.dly) ? v.rdata : $urandom;
         req_i     = (k < v.lat);
         @(posedge CLK); #1;
         wbs_ack_i = 1'b0;
         req_i     = 1'b0;
         if (done_o) begin
            got = 1'b1;
         end else begin
            chk("hold_ctl",
                {wbs_cyc_o, wbs_stb_o, wbs_we_o, busy_o, wbs_sel_o},
                {1'b1, 1'b1, v.we, 1'b1, v.sel});
            chk("hold_adr", wbs_adr_o, v.adr);
            chk("hold_dat", wbs_dat_o, v.dat);
         end
      end
      chk("latency", k, v.lat);
      chk("err", err_o, v.err);
      chk("rdat", rdat_o, v.rdat);
      chk("end_ctl", {wbs_cyc_o, wbs_stb_o, wbs_we_o, busy_o, wbs_sel_o}, 0);
      chk("end_adr_dat", wbs_adr_o | wbs_dat_o, 0);
      @(posedge CLK); #1;
      chk("done_pulse", {done_o, wbs_cyc_o}, 0);
   endtask

   initial begin
      vec_t v;
      int   ndone;

      // reset with a pending request
      nRST = 1'b0;
      req_i = 1'b1;
      we_req_i = 1'b1;
      adr_req_i = 32'h3001_0000;
      dat_req_i = 32'h1;
      sel_req_i = 4'hF;
      wbs_ack_i = 1'b0;
      wbs_dat_i = '0;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_ctl", {wbs_cyc_o, wbs_stb_o, wbs_we_o, busy_o, done_o,
                      err_o, wbs_sel_o}, 0);
      chk("rst_adr_dat", wbs_adr_o | wbs_dat_o, 0);
      chk("rst_rdat", rdat_o, 0);
      req_i = 1'b0;
      nRST = 1'b1;
      wbs_ack_i = 1'b1;
      wbs_dat_i = 32'hFFFF_FFFF;
      repeat (3) @(posedge CLK);
      #1;
      chk("idle_quiet", {done_o, err_o, wbs_cyc_o, busy_o}, 0);
      chk("idle_ack_rdat", rdat_o, 0);
      wbs_ack_i = 1'b0;

      // directed table
      vq.push_back('{1'b1, 32'h3001_0004, 32'hDEAD_BEEF, 4'hF, 2,
                     32'hBAD0_0001, 1'b0, 32'h0, 2});
      vq.push_back('{1'b0, 32'h3300_0010, 32'h0, 4'hF, 3,
                     32'h1234_5678, 1'b0, 32'h1234_5678, 3});
      vq.push_back('{1'b1, 32'h3200_0000, 32'h0000_00A5, 4'h1, 1,
                     32'hBAD0_0002, 1'b0, 32'h1234_5678, 1});
      vq.push_back('{1'b0, 32'h3100_0008, 32'h0, 4'hF, 5,
                     32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 5});
`ifdef WB_MANAGER_TIMEOUT_EN
      vq.push_back('{1'b0, 32'h3300_0020, 32'h0, 4'hF, 0,
                     32'h0, 1'b1, 32'h0, 8});
      vq.push_back('{1'b0, 32'h3300_0024, 32'h0, 4'h3, 8,
                     32'h55AA_55AA, 1'b0, 32'h55AA_55AA, 8});
      vq.push_back('{1'b1, 32'h3000_0100, 32'h1111_2222, 4'hF, 9,
                     32'hBAD0_0003, 1'b1, 32'h0, 8});
`endif
      foreach (vq[i]) run_txn(vq[i]);
      m_rdat = vq[vq.size()-1].rdat;

      // back-to-back: req held high, second accepted in the done cycle
      req_i = 1'b1;
      we_req_i = 1'b0;
      adr_req_i = 32'h3300_0100;
      dat_req_i = 32'h0;
      sel_req_i = 4'hF;
      @(posedge CLK); #1;
      chk("b2b_first", wbs_adr_o, 32'h3300_0100);
      we_req_i = 1'b1;
      adr_req_i = 32'h3000_0200;
      dat_req_i = 32'h7777_0000;
      ndone = 0;
      for (int c = 1; c <= 14; c++) begin
         wbs_ack_i = (c == 2) || (c == 5);
         wbs_dat_i = (c == 2) ? 32'h0BAD_F00D : 32'h5151_5151;
         @(posedge CLK); #1;
         wbs_ack_i = 1'b0;
         if (done_o) ndone++;
         if (c == 1) chk("b2b_ignored", wbs_adr_o, 32'h3300_0100);
         if (c == 3) begin
            chk("b2b_restart", {wbs_cyc_o, wbs_stb_o, wbs_we_o, done_o},
                4'b1110);
            chk("b2b_second", wbs_adr_o, 32'h3000_0200);
            req_i = 1'b0;
         end
      end
      chk("b2b_done_count", ndone, 2);
      chk("b2b_rdat", rdat_o, 32'h0BAD_F00D);

      // asynchronous reset during BUS
      req_i = 1'b1;
      we_req_i = 1'b0;
      adr_req_i = 32'h3300_0200;
      @(posedge CLK); #1;
      req_i = 1'b0;
      @(posedge CLK); #2;
      nRST = 1'b0;
      #1;
      chk("async_rst", {wbs_cyc_o, wbs_stb_o, busy_o, done_o}, 0);
      chk("async_rst_adr", wbs_adr_o, 0);
      @(posedge CLK); #1;
      nRST = 1'b1;
      ndone = 0;
      for (int c = 0; c < 3; c++) begin
         wbs_ack_i = 1'b1;
         @(posedge CLK); #1;
         if (done_o || wbs_cyc_o) ndone++;
      end
      wbs_ack_i = 1'b0;
      chk("rst_no_done", ndone, 0);
      m_rdat = '0;
      v = '{1'b0, 32'h3300_0204, 32'h0, 4'hF, 2, 32'hA5A5_0001,
            1'b0, 32'h0, 0};
      model(v);
      run_txn(v);

      // randomized transactions
      for (int n = 0; n < 40; n++) begin
         v.we    = 1'($urandom);
         v.adr   = $urandom;
         v.dat   = $urandom;
         v.sel   = 4'($urandom);
         v.rdata = $urandom;
         v.dly   = TMO ? int'($urandom_range(0, 12))
                       : int'($urandom_range(1, 12));
         model(v);
         run_txn(v);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
